// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, data-length encodings and oversample ratio.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    localparam logic [1:0] DLS_5 = 2'b00;
    localparam logic [1:0] DLS_6 = 2'b01;
    localparam logic [1:0] DLS_7 = 2'b10;
    localparam logic [1:0] DLS_8 = 2'b11;

    localparam int unsigned UART_OVERSAMPLE = 16;

endpackage

// File: rtl/uart_baud_gen.sv
// Baud tick generator: one-cycle tick every div+1 clocks; synchronous clear restarts the count.
module uart_baud_gen #(
    parameter int unsigned UBRR_W = 12
) (
    input  logic              pClk,
    input  logic              pReset,
    input  logic              clr,
    input  logic [UBRR_W-1:0] div,
    output logic              tick
);

    logic [UBRR_W-1:0] cnt_q, cnt_d;

    // Compare-and-wrap keeps div = all-ones legal without a wider counter.
    assign tick = !clr && (cnt_q == div);

    always_comb begin
        cnt_d = cnt_q + UBRR_W'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART serial transmit engine: start, 5-8 data bits LSB first, optional parity, 1-2 stop bits.
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
    parameter int unsigned UBRR_W     = 12
) (
    input  logic              pClk,
    input  logic              pReset,
    input  logic              TxStart,
    input  logic [7:0]        TxData,
    input  logic [UBRR_W-1:0] Ubrr,
    input  logic [1:0]        Dls,
    input  logic              StopBits,
    input  logic              Pen,
    input  logic              Eps,
    output logic              TxD,
    output logic              TxBusy,
    output logic              TxDone
);

    localparam int unsigned TickW = $clog2(OVERSAMPLE);

    uart_tx_state_t    state_q, state_d;
    logic [7:0]        shift_q, shift_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic              stop_idx_q, stop_idx_d;
    logic [TickW-1:0]  tick_cnt_q, tick_cnt_d;
    logic [1:0]        dls_q, dls_d;
    logic              stop2_q, stop2_d;
    logic [UBRR_W-1:0] ubrr_q, ubrr_d;
    logic              txd_q, txd_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic tick;
    logic bit_end;
    logic last_data;
    logic baud_clr;

`ifdef UART_TX_PARITY_EN
    logic pen_q, pen_d;
    logic eps_q, eps_d;
    logic parity_q, parity_d;
`else
    logic unused_cfg;
    assign unused_cfg = Pen ^ Eps;
`endif

    assign baud_clr  = (state_q == IDLE);
    assign bit_end   = tick && (tick_cnt_q == TickW'(OVERSAMPLE - 1));
    assign last_data = (bit_idx_q == ({1'b0, dls_q} + 3'd4));

    uart_baud_gen #(
        .UBRR_W (UBRR_W)
    ) u_baud_gen (
        .pClk   (pClk),
        .pReset (pReset),
        .clr    (baud_clr),
        .div    (ubrr_q),
        .tick   (tick)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        dls_d      = dls_q;
        stop2_d    = stop2_q;
        ubrr_d     = ubrr_q;
        txd_d      = txd_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
        pen_d      = pen_q;
        eps_d      = eps_q;
        parity_d   = parity_q;
`endif
        if (state_q == IDLE) begin
            tick_cnt_d = '0;
        end else if (tick) begin
            tick_cnt_d = tick_cnt_q + TickW'(1);
        end else begin
            tick_cnt_d = tick_cnt_q;
        end

        unique case (state_q)
            IDLE: begin
                txd_d  = 1'b1;
                busy_d = 1'b0;
                if (TxStart) begin
                    state_d    = START;
                    shift_d    = TxData;
                    dls_d      = Dls;
                    stop2_d    = StopBits;
                    ubrr_d     = Ubrr;
                    bit_idx_d  = '0;
                    stop_idx_d = 1'b0;
                    txd_d      = 1'b0;
                    busy_d     = 1'b1;
`ifdef UART_TX_PARITY_EN
                    pen_d      = Pen;
                    eps_d      = Eps;
                    parity_d   = 1'b0;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    txd_d   = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
`ifdef UART_TX_PARITY_EN
                    parity_d = parity_q ^ shift_q[0];
`endif
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (last_data) begin
`ifdef UART_TX_PARITY_EN
                        if (pen_q) begin
                            state_d = PARITY;
                            // Even parity sends the XOR; odd sends its inverse.
                            txd_d   = parity_q ^ ~eps_q;
                        end else
`endif
                        begin
                            state_d    = STOP;
                            stop_idx_d = 1'b0;
                            txd_d      = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        txd_d     = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
`ifdef UART_TX_PARITY_EN
                        parity_d  = parity_q ^ shift_q[0];
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d    = STOP;
                    stop_idx_d = 1'b0;
                    txd_d      = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (stop2_q && !stop_idx_q) begin
                        stop_idx_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        txd_d   = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            tick_cnt_q <= '0;
            dls_q      <= DLS_5;
            stop2_q    <= 1'b0;
            ubrr_q     <= '0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            tick_cnt_q <= tick_cnt_d;
            dls_q      <= dls_d;
            stop2_q    <= stop2_d;
            ubrr_q     <= ubrr_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) begin
            pen_q    <= 1'b0;
            eps_q    <= 1'b0;
            parity_q <= 1'b0;
        end else begin
            pen_q    <= pen_d;
            eps_q    <= eps_d;
            parity_q <= parity_d;
        end
    end
`endif

    assign TxD    = txd_q;
    assign TxBusy = busy_q;
    assign TxDone = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx; expectations follow UART_TX_PARITY_EN when defined.
module tb_uart_tx;

    logic        pClk;
    logic        pReset;
    logic        TxStart;
    logic [7:0]  TxData;
    logic [11:0] Ubrr;
    logic [1:0]  Dls;
    logic        StopBits;
    logic        Pen;
    logic        Eps;
    logic        TxD;
    logic        TxBusy;
    logic        TxDone;

    int n_vec = 0;
    int n_err = 0;

    uart_tx #(
        .OVERSAMPLE (16),
        .UBRR_W     (12)
    ) dut (
        .pClk     (pClk),
        .pReset   (pReset),
        .TxStart  (TxStart),
        .TxData   (TxData),
        .Ubrr     (Ubrr),
        .Dls      (Dls),
        .StopBits (StopBits),
        .Pen      (Pen),
        .Eps      (Eps),
        .TxD      (TxD),
        .TxBusy   (TxBusy),
        .TxDone   (TxDone)
    );

    initial pClk = 1'b0;
    always #5 pClk = ~pClk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; the following posedge is the accept edge.
    task automatic start_frame(input logic [7:0] data, input logic [1:0] dls, input logic stop2,
                               input logic pen, input logic eps, input logic [11:0] ubrr);
        TxStart  = 1'b1;
        TxData   = data;
        Dls      = dls;
        StopBits = stop2;
        Pen      = pen;
        Eps      = eps;
        Ubrr     = ubrr;
        @(negedge pClk);
        TxStart = 1'b0;
    endtask

    // Walks offsets 1..F*B+1 after accept; ends at the negedge of the TxDone cycle.
    // mode 1: stray TxStart with 0x00 at dist_at; mode 2: rewrite config/data at dist_at.
    task automatic check_frame(input string name, input logic [11:0] exp_bits, input int nbits,
                               input int bper, input int mode, input int dist_at);
        int k;
        int p;
        int last;
        last = nbits * bper;
        for (int o = 1; o <= last + 1; o++) begin
            if (o <= last) begin
                k = (o - 1) / bper;
                p = (o - 1) % bper;
                if (p == 0 || p == bper / 2 || p == bper - 1)
                    chk($sformatf("%s bit%0d@%0d", name, k, p), TxD, exp_bits[k]);
                if (p == bper / 2)
                    chk($sformatf("%s busy bit%0d", name, k), TxBusy, 1);
            end
            if (o == last) chk({name, " done early"}, TxDone, 0);
            if (o == last + 1) begin
                chk({name, " done"}, TxDone, 1);
                chk({name, " busy end"}, TxBusy, 0);
                chk({name, " idle line"}, TxD, 1);
            end
            if (mode == 1 && o == dist_at) begin
                TxStart = 1'b1;
                TxData  = 8'h00;
            end
            if (mode == 1 && o == dist_at + 1) TxStart = 1'b0;
            if (mode == 2 && o == dist_at) begin
                Ubrr     = 12'd5;
                TxData   = 8'h00;
                Dls      = 2'b00;
                StopBits = 1'b1;
                Pen      = 1'b1;
            end
            if (o <= last) @(negedge pClk);
        end
    endtask

    initial begin
        logic seen_bad;
        pReset   = 1'b0;
        TxStart  = 1'b0;
        TxData   = 8'h00;
        Ubrr     = 12'd0;
        Dls      = 2'b11;
        StopBits = 1'b0;
        Pen      = 1'b0;
        Eps      = 1'b0;
        repeat (3) @(negedge pClk);
        chk("reset txd", TxD, 1);
        chk("reset busy", TxBusy, 0);
        chk("reset done", TxDone, 0);
        pReset = 1'b1;
        repeat (2) @(negedge pClk);

        // 8N1 0xA5: 0,1,0,1,0,0,1,0,1,1 (bit0 first)
        start_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 12'd0);
        check_frame("8n1_a5", 12'b0011_0100_1010, 10, 16, 0, 0);

        // 5E2 0xFF Ubrr=2: 0,1,1,1,1,1,[par 1],1,1
        @(negedge pClk);
        start_frame(8'hFF, 2'b00, 1'b1, 1'b1, 1'b1, 12'd2);
`ifdef UART_TX_PARITY_EN
        check_frame("5e2_ff", 12'b0001_1111_1110, 9, 48, 0, 0);
`else
        check_frame("5e2_ff", 12'b0000_1111_1110, 8, 48, 0, 0);
`endif

        // 7O1 0x03: 0,1,1,0,0,0,0,0,[par 1],1
        @(negedge pClk);
        start_frame(8'h03, 2'b10, 1'b0, 1'b1, 1'b0, 12'd0);
`ifdef UART_TX_PARITY_EN
        check_frame("7o1_03", 12'b0011_0000_0110, 10, 16, 0, 0);
`else
        check_frame("7o1_03", 12'b0001_0000_0110, 9, 16, 0, 0);
`endif

        // 8N1 0x5A with stray strobe, then 0x3C accepted in the TxDone cycle
        @(negedge pClk);
        start_frame(8'h5A, 2'b11, 1'b0, 1'b0, 1'b0, 12'd0);
        check_frame("8n1_5a", 12'b0010_1011_0100, 10, 16, 1, 50);
        start_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 12'd0);
        check_frame("b2b_3c", 12'b0010_0111_1000, 10, 16, 0, 0);

        // 8N1 0xC3 Ubrr=1 with config rewritten mid-frame
        @(negedge pClk);
        start_frame(8'hC3, 2'b11, 1'b0, 1'b0, 1'b0, 12'd1);
        check_frame("shadow_c3", 12'b0011_1000_0110, 10, 32, 2, 69);

        // Reset mid-DATA
        @(negedge pClk);
        start_frame(8'hFF, 2'b11, 1'b0, 1'b0, 1'b0, 12'd0);
        repeat (3 * 16 + 4) @(negedge pClk);
        chk("pre-reset txd", TxD, 1);
        pReset = 1'b0;
        #1;
        chk("async rst txd", TxD, 1);
        chk("async rst busy", TxBusy, 0);
        seen_bad = 1'b0;
        repeat (3) begin
            @(negedge pClk);
            if (TxDone !== 1'b0 || TxD !== 1'b1) seen_bad = 1'b1;
        end
        pReset = 1'b1;
        repeat (200) begin
            @(negedge pClk);
            if (TxDone !== 1'b0 || TxD !== 1'b1 || TxBusy !== 1'b0) seen_bad = 1'b1;
        end
        chk("no done after reset", seen_bad, 0);

        // 8N1 0x55 after reset: 0,1,0,1,0,1,0,1,0,1
        start_frame(8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 12'd0);
        check_frame("post_rst_55", 12'b0010_1010_1010, 10, 16, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmit engine for the UART. It sits directly downstream of the APB register/FIFO block, which supplies the transmit byte and a start strobe. It turns that byte into an asynchronous serial frame: start bit, 5–8 data bits LSB first, optional parity, and 1 or 2 stop bits. Timing comes from an internal 16x-oversampled baud generator driven by the UBRR divisor. It pulses `TxDone` back to the register block so the next FIFO entry can be loaded.

## Interface
Parameters:
- `OVERSAMPLE`, default 16: baud ticks per bit; must be a power of two.
- `UBRR_W`, default 12: divisor width (`UBRRH:UBRR`).

Ports:
- `pClk` in 1: system clock.
- `pReset` in 1: asynchronous, active-low reset; clock is pClk.
- `TxStart` in 1: single-cycle start strobe; honoured only while idle.
- `TxData` in 8: byte to send; sampled on the accepted `TxStart`.
- `Ubrr` in `UBRR_W`: baud divisor; tick period is Ubrr+1 clocks.
- `Dls` in 2: data length; 00=5, 01=6, 10=7, 11=8 bits.
- `StopBits` in 1: 0 = one stop bit, 1 = two stop bits.
- `Pen` in 1: parity enable.
- `Eps` in 1: 1 = even parity, 0 = odd parity.
- `TxD` out 1: serial line; idles high.
- `TxBusy` out 1: high from the cycle after accept until the frame ends.
- `TxDone` out 1: one-cycle pulse at end of frame.

## Operation
- Reset values: `TxD`=1, `TxBusy`=0, `TxDone`=0. The FSM is in IDLE and all counters are 0.
- States: IDLE → START → DATA → [PARITY] → STOP → IDLE.
- IDLE: `TxStart`=1 latches the following into a shadow register:
  - `TxData`, `Dls`, `StopBits`, `Pen`, `Eps`, `Ubrr`.
  - The baud and bit counters are cleared. The FSM goes to START.
- START: `TxD`=0 for one bit period.
- DATA: shift register LSB first. `TxD` carries one data bit per bit period. The bit index runs 0..N-1, where N=Dls+5; then the FSM goes to PARITY if Pen, else STOP.
- PARITY: `TxD` = XOR of the N transmitted bits when Eps=1, or its inverse when Eps=0. Bits above N-1 are excluded.
- STOP: `TxD`=1 for 1 or 2 bit periods. At the end of the period the FSM goes to IDLE and `TxDone` pulses.
- Bit period = `OVERSAMPLE`*(Ubrr+1) pClk cycles, using the latched Ubrr.
- Baud counter: counts 0..Ubrr, then wraps and emits a tick. A 4-bit tick counter advances the bit on wrap 15→0.
- Config or `TxData` changes mid-frame have no effect (shadowed).
- `TxStart` while busy is ignored and not queued.
- `TxStart` in the same cycle as `TxDone` is accepted. This gives a back-to-back frame with no idle gap.
- Ubrr = all-ones is legal: the counter width is `UBRR_W` and no overflow occurs.
- Reset asserted mid-frame: `TxD` returns to 1 and `TxBusy` to 0 asynchronously. No `TxDone` is generated.

## Timing
- Accept at cycle A (`TxStart`=1 in IDLE): `TxD` falls at A+1 and `TxBusy` rises at A+1. Both are registered outputs.
- Each bit, including start, parity and stop, holds for exactly one bit period B.
- `TxDone` is high for exactly one cycle, at A+1+F·B, where F = 1 + N + Pen + (StopBits+1). `TxBusy` is low in that same cycle.
- `TxD` is glitch-free: driven straight from a flop.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state and parity logic are compiled in, and `Pen`/`Eps` behave as above.
- `UART_TX_PARITY_EN` undefined: the PARITY state is absent, `Pen`/`Eps` are ignored, and frames never carry parity. F = 1 + N + StopBits + 1.

## Structure
- Shared package `uart_pkg` holds:
  - FSM state enum `uart_tx_state_t` (IDLE, START, DATA, PARITY, STOP).
  - `DLS_5`..`DLS_8` encodings.
  - `UART_OVERSAMPLE` constant.
- One sub-module, `uart_baud_gen`:
  - Inputs: `pClk`, `pReset`, a synchronous clear, and the divisor.
  - Output: a 1-cycle `tick` every Ubrr+1 cycles.
  - To be reused by the future `uart_rx`.
- The top level contains the FSM, the shadow registers, the shift register, the bit/tick counters and the parity accumulator.

## Test plan
- 8N1, Ubrr=0, `TxData`=0xA5:
  - Bit period is 16 cycles and the frame is 160 cycles.
  - `TxD` sequence: 0,1,0,1,0,0,1,0,1,1.
  - `TxDone` pulse at A+161.
- 5-bit, even parity, 2 stop, Ubrr=2, `TxData`=0xFF:
  - Bit period is 48 cycles.
  - `TxD` sequence: 0,1,1,1,1,1, parity 1, 1,1.
  - Bits 5–7 are never sent.
- 7-bit, odd parity, `TxData`=0x03: parity bit = 1.
  - Without `UART_TX_PARITY_EN`: no parity bit, and `TxDone` comes one bit period earlier.
- `TxStart` pulsed mid-frame with 0x00, then again in the `TxDone` cycle with 0x3C:
  - The first strobe is ignored.
  - The second frame's start bit begins the next cycle with no idle gap.
- `Ubrr` and `TxData` changed mid-frame: the frame is unaffected and bit periods are unchanged.
- `pReset` low mid-DATA:
  - `TxD`=1 and `TxBusy`=0 immediately; no `TxDone`.
  - After release, a new 0x55 frame transmits correctly.
